// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ready,
    input  logic [3:0]         op,
    input  logic               alurt,
    input  logic [1:0]         alurssa,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     shval_q, shval_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           kind_q, kind_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 illegal_q, illegal_d;

    logic                 accept;
    logic                 is_shift;
    logic                 amt_src_ok;
    logic                 start_iter;
    logic [SHAMT_W-1:0]   shift_amt;
    logic [WIDTH-1:0]     shift_src;
    logic [WIDTH-1:0]     shift_step;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     imm_result;
    logic                 imm_ovf;
    logic                 imm_illegal;

    assign accept     = start && (state_q == IDLE);
    assign is_shift   = (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    assign amt_src_ok = (alurssa == 2'd1) || (alurssa == 2'd2);
    assign shift_amt  = (alurssa == 2'd1) ? shamt : rs[SHAMT_W-1:0];
    assign shift_src  = alurt ? rt : rs;
    assign sum        = rs + rt;
    assign diff       = rs - rt;

`ifdef ALU_FAST_SHIFT_EN
    assign start_iter = 1'b0;
`else
    // Only a legal shift with a non-zero amount needs the SHIFT state.
    assign start_iter = is_shift && amt_src_ok && (shift_amt != '0);
`endif

    always_comb begin
        imm_result  = '0;
        imm_ovf     = 1'b0;
        imm_illegal = 1'b0;
        case (op)
            4'd0: begin
                imm_result = sum;
                imm_ovf    = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            4'd1: begin
                imm_result = diff;
                imm_ovf    = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            4'd2: imm_result = rs & rt;
            4'd3: imm_result = rs | rt;
            4'd4: imm_result = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            4'd8: imm_result = rs ^ rt;
            4'd9: imm_result = {{(WIDTH-1){1'b0}}, (rs < rt)};
            4'd5, 4'd6, 4'd7: begin
                if (!amt_src_ok) begin
                    imm_illegal = 1'b1;
                end else begin
`ifdef ALU_FAST_SHIFT_EN
                    case (op)
                        4'd5:    imm_result = shift_src << shift_amt;
                        4'd6:    imm_result = shift_src >> shift_amt;
                        default: imm_result = WIDTH'($signed(shift_src) >>> shift_amt);
                    endcase
`else
                    imm_result = shift_src;
`endif
                end
            end
            default: imm_illegal = 1'b1;
        endcase
    end

    // kind_q holds op[1:0] of the accepted shift: 1 sll, 2 srl, 3 sra.
    always_comb begin
        case (kind_q)
            2'd1:    shift_step = {shval_q[WIDTH-2:0], 1'b0};
            2'd2:    shift_step = {1'b0, shval_q[WIDTH-1:1]};
            default: shift_step = {shval_q[WIDTH-1], shval_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = start_iter ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        shval_d   = shval_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        if (accept && !start_iter) begin
            result_d  = imm_result;
            zero_d    = (imm_result == '0);
            ovf_d     = imm_ovf;
            illegal_d = imm_illegal;
        end else if (accept && start_iter) begin
            shval_d = shift_src;
            cnt_d   = shift_amt;
            kind_d  = op[1:0];
        end else if (state_q == SHIFT) begin
            shval_d = shift_step;
            cnt_d   = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                result_d  = shift_step;
                zero_d    = (shift_step == '0);
                ovf_d     = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    always_comb begin
        ready   = (state_q == IDLE);
        done    = (state_q == FIN);
        result  = result_q;
        zero    = zero_q;
        ovf     = ovf_q;
        illegal = illegal_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            shval_q   <= '0;
            cnt_q     <= '0;
            kind_q    <= '0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            shval_q   <= shval_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
        end
    end

endmodule
